// File: rtl/decode_scoreboard.sv
// Decode-stage register hazard scoreboard: tracks pending scalar/vector writes,
// stalls on RAW/WAW, drains on request. Optional macro DECODE_SCOREBOARD_PERF_EN.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   issue_valid              decode presents an instruction
//   rs1/rs2 (+_used, _vec)   source indices, read enable, vector-file select
//   rd, rd_scalar_we/vec_we  destination index and target files
//   wb_scalar_we/vec_we,wb_rd write-back clears
//   drain_req                request to empty all in-flight writes
//   stall, issue_fire        decode hold / instruction accepted
//   drain_ack                one-cycle pulse once drained
//   pending_scalar/vec       per-register pending bits
//   busy                     any pending bit set
//   wb_err                   sticky write-back to a non-pending register
//   stall_cycles,            (perf macro only) saturating cycle counters
//   hazard_cycles
module decode_scoreboard #(
  parameter int NREGS      = 32,
  parameter int REG_W      = 5,
  parameter int R0_IS_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             rs1_vec,
  input  logic             rs2_vec,
  input  logic [REG_W-1:0] rd,
  input  logic             rd_scalar_we,
  input  logic             rd_vec_we,
  input  logic             wb_scalar_we,
  input  logic             wb_vec_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             drain_req,
  output logic             stall,
  output logic             issue_fire,
  output logic             drain_ack,
  output logic [NREGS-1:0] pending_scalar,
  output logic [NREGS-1:0] pending_vec,
  output logic             busy,
  output logic             wb_err
`ifdef DECODE_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      hazard_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NREGS-1:0] s_mask;
  logic [NREGS-1:0] s_eff;
  logic [NREGS-1:0] s_set, s_clr, s_nxt;
  logic [NREGS-1:0] v_set, v_clr, v_nxt;
  logic             raw1, raw2, waw, hazard;
  logic             err_now;
  logic             nxt_empty;

  // Scalar r0 is masked out entirely when it is hardwired to zero.
  always_comb begin
    s_mask = '1;
    if (R0_IS_ZERO != 0) s_mask[0] = 1'b0;
  end

  assign s_eff = pending_scalar & s_mask;

  always_comb begin
    raw1   = rs1_used &
             (rs1_vec ? pending_vec[rs1] : s_eff[rs1]);
    raw2   = rs2_used &
             (rs2_vec ? pending_vec[rs2] : s_eff[rs2]);
    waw    = (rd_scalar_we & s_eff[rd]) |
             (rd_vec_we & pending_vec[rd]);
    hazard = raw1 | raw2 | waw;
  end

  // No write-back bypass: hazard uses registered pending state only.
  assign stall      = issue_valid &
                      (hazard | (state != RUN) | drain_req);
  assign issue_fire = issue_valid & ~stall;

  always_comb begin
    s_clr = '0;
    v_clr = '0;
    s_set = '0;
    v_set = '0;
    if (wb_scalar_we) s_clr[wb_rd] = 1'b1;
    if (wb_vec_we)    v_clr[wb_rd] = 1'b1;
    if (issue_fire & rd_scalar_we) s_set[rd] = 1'b1;
    if (issue_fire & rd_vec_we)    v_set[rd] = 1'b1;
    s_set = s_set & s_mask;
    // Set applied after clear so a same-cycle reissue stays pending.
    s_nxt = (pending_scalar & ~s_clr) | s_set;
    v_nxt = (pending_vec & ~v_clr) | v_set;
  end

  assign nxt_empty = ~(|s_nxt) & ~(|v_nxt);

  assign err_now = (wb_scalar_we & ~pending_scalar[wb_rd]) |
                   (wb_vec_we & ~pending_vec[wb_rd]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_scalar <= '0;
      pending_vec    <= '0;
      wb_err         <= 1'b0;
    end else begin
      pending_scalar <= s_nxt;
      pending_vec    <= v_nxt;
      if (err_now) wb_err <= 1'b1;
    end
  end

  assign busy = (|pending_scalar) | (|pending_vec);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (nxt_empty) state_nxt = ACK;
      ACK:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    drain_ack = (state == ACK);
  end

`ifdef DECODE_SCOREBOARD_PERF_EN
  logic hz_cnt;
  assign hz_cnt = issue_valid & hazard & (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      hazard_cycles <= '0;
    end else begin
      if (stall && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (hz_cnt && hazard_cycles != 32'hFFFF_FFFF)
        hazard_cycles <= hazard_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed self-checking bench for decode_scoreboard.
// Linear stimulus, immediate assertions at each check.
module tb_decode_scoreboard;

  localparam int NREGS = 32;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [REG_W-1:0] rs1, rs2, rd, wb_rd;
  logic             rs1_used, rs2_used, rs1_vec, rs2_vec;
  logic             rd_scalar_we, rd_vec_we;
  logic             wb_scalar_we, wb_vec_we;
  logic             drain_req;
  logic             stall, issue_fire, drain_ack, busy, wb_err;
  logic [NREGS-1:0] pending_scalar, pending_vec;
`ifdef DECODE_SCOREBOARD_PERF_EN
  logic [31:0]      stall_cycles, hazard_cycles;
  logic [31:0]      sc0, hc0;
`endif

  int n_chk = 0;
  int n_err = 0;

  decode_scoreboard #(
    .NREGS(NREGS), .REG_W(REG_W), .R0_IS_ZERO(0)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_vec(rs1_vec), .rs2_vec(rs2_vec),
    .rd(rd),
    .rd_scalar_we(rd_scalar_we), .rd_vec_we(rd_vec_we),
    .wb_scalar_we(wb_scalar_we), .wb_vec_we(wb_vec_we),
    .wb_rd(wb_rd),
    .drain_req(drain_req),
    .stall(stall), .issue_fire(issue_fire),
    .drain_ack(drain_ack),
    .pending_scalar(pending_scalar),
    .pending_vec(pending_vec),
    .busy(busy), .wb_err(wb_err)
`ifdef DECODE_SCOREBOARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .hazard_cycles(hazard_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid  = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
    rs1_used = 0; rs2_used = 0;
    rs1_vec = 0; rs2_vec = 0;
    rd_scalar_we = 0; rd_vec_we = 0;
    wb_scalar_we = 0; wb_vec_we = 0;
    drain_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", drain_ack, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_ps", pending_scalar, 0);
    chk("rst_pv", pending_vec, 0);
    @(negedge clk);
    rst = 0;
    tick();

    // RAW on scalar r3, no write-back bypass
    issue_valid = 1; rd = 3; rd_scalar_we = 1;
    #1;
    chk("r3_issue_fire", issue_fire, 1);
    tick();
    chk("r3_pending", pending_scalar, 64'h8);
    chk("r3_busy", busy, 1);
    idle();
    issue_valid = 1; rs1 = 3; rs1_used = 1;
    #1;
    chk("r3_raw_stall", stall, 1);
    tick();
    wb_scalar_we = 1; wb_rd = 3;
    #1;
    chk("r3_wb_nobypass", stall, 1);
    chk("r3_wb_fire0", issue_fire, 0);
    tick();
    wb_scalar_we = 0;
    #1;
    chk("r3_clr", pending_scalar, 0);
    chk("r3_after_stall", stall, 0);
    chk("r3_after_fire", issue_fire, 1);
    tick();

    // Vector v7 vs scalar r7 independence
    idle();
    issue_valid = 1; rd = 7; rd_vec_we = 1;
    tick();
    chk("v7_pending", pending_vec, 64'h80);
    chk("v7_ps_clean", pending_scalar, 0);
    idle();
    issue_valid = 1; rs2 = 7; rs2_used = 1; rs2_vec = 0;
    #1;
    chk("s7_read_nostall", stall, 0);
    tick();
    rs2_vec = 1;
    #1;
    chk("v7_read_stall", stall, 1);
    tick();
    chk("v7_read_stall2", stall, 1);
    wb_vec_we = 1; wb_rd = 7;
    #1;
    chk("v7_wb_stall", stall, 1);
    tick();
    wb_vec_we = 0;
    #1;
    chk("v7_released", stall, 0);
    chk("v7_clr", pending_vec, 0);
    tick();

    // Write-back to non-pending r12
    idle();
    chk("err_before", wb_err, 0);
    wb_scalar_we = 1; wb_rd = 12;
    tick();
    idle();
    chk("err_set", wb_err, 1);
    chk("err_ps", pending_scalar, 0);
    tick();
    chk("err_sticky", wb_err, 1);

    // Same-cycle clear and set on r9: set wins
    idle();
    issue_valid = 1; rd = 9; rd_scalar_we = 1;
    wb_scalar_we = 1; wb_rd = 9;
    #1;
    chk("r9_fire", issue_fire, 1);
    tick();
    wb_scalar_we = 0;
    #1;
    chk("r9_set_wins", pending_scalar, 64'h200);
    chk("r9_waw", stall, 1);
    idle();
    wb_scalar_we = 1; wb_rd = 9;
    tick();
    idle();
    chk("r9_clr", pending_scalar, 0);

    // Drain with r1, r2, v4 outstanding
    issue_valid = 1; rd = 1; rd_scalar_we = 1;
    tick();
    rd = 2;
    tick();
    rd_scalar_we = 0; rd = 4; rd_vec_we = 1;
    tick();
    idle();
    chk("dr_ps", pending_scalar, 64'h6);
    chk("dr_pv", pending_vec, 64'h10);
    issue_valid = 1; drain_req = 1;
    #1;
    chk("dr_req_stall", stall, 1);
    chk("dr_req_fire", issue_fire, 0);
    tick();
    drain_req = 0;
    #1;
    chk("dr_drain_stall", stall, 1);
    wb_scalar_we = 1; wb_rd = 1;
    tick();
    wb_rd = 2;
    #1;
    chk("dr_ack0", drain_ack, 0);
    tick();
    wb_scalar_we = 0; wb_vec_we = 1; wb_rd = 4;
    #1;
    chk("dr_ack1", drain_ack, 0);
    tick();
    wb_vec_we = 0;
    #1;
    chk("dr_ack", drain_ack, 1);
    chk("dr_ack_stall", stall, 1);
    chk("dr_busy", busy, 0);
    tick();
    chk("dr_ack_once", drain_ack, 0);
    chk("dr_run_stall", stall, 0);

    // Drain while already empty: ack two cycles later
    idle();
    drain_req = 1;
    tick();
    drain_req = 0;
    #1;
    chk("de_ack_c1", drain_ack, 0);
    tick();
    chk("de_ack_c2", drain_ack, 1);
    tick();
    chk("de_ack_c3", drain_ack, 0);

    // Async reset mid-drain
    issue_valid = 1; rd = 5; rd_scalar_we = 1;
    tick();
    idle();
    drain_req = 1;
    tick();
    drain_req = 0;
    issue_valid = 1;
    #1;
    chk("rm_in_drain", stall, 1);
    #2;
    rst = 1;
    #1;
    chk("rm_ps", pending_scalar, 0);
    chk("rm_busy", busy, 0);
    chk("rm_stall", stall, 0);
    chk("rm_err", wb_err, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_no_ack", drain_ack, 0);
    end

`ifdef DECODE_SCOREBOARD_PERF_EN
    // 5-cycle RAW stall then an empty drain (RUN, DRAIN, ACK)
    idle();
    issue_valid = 1; rd = 3; rd_scalar_we = 1;
    tick();
    sc0 = stall_cycles; hc0 = hazard_cycles;
    idle();
    issue_valid = 1; rs1 = 3; rs1_used = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        wb_scalar_we = 1; wb_rd = 3;
      end
      tick();
    end
    idle();
    issue_valid = 1; drain_req = 1;
    tick();
    drain_req = 0;
    tick();
    tick();
    idle();
    chk("perf_stall", stall_cycles - sc0, 8);
    chk("perf_hazard", hazard_cycles - hc0, 5);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
